loader_cmd_sequencer: RTL



---
 rtl/loader_cmd_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/loader_cmd_sequencer.sv
// loader_cmd_sequencer: turns FM-write and kernel-refill request streams into
// the loader's sig_1/sig_2/sig_3 command words and closes each request when the
// loader echoes its transaction ID on sig_in (or abandons it after a timeout).
module loader_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FM_ADDR_W      = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          sig_in,
  input  logic                 fm_req_valid,
  output logic                 fm_req_ready,
  input  logic [15:0]          fm_req_data,
  input  logic [FM_ADDR_W-1:0] fm_req_addr,
  input  logic                 kern_req_valid,
  output logic                 kern_req_ready,
  input  logic                 kern_req_slot,
  output logic [31:0]          sig_1,
  output logic [31:0]          sig_2,
  output logic [31:0]          sig_3,
  output logic                 init_done,
  output logic                 fm_done,
  output logic                 kern_done,
  output logic                 err_timeout
);

  // Counter only has to reach TIMEOUT_CYCLES-1, so clog2 bits are enough.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {TOP_INIT, TOP_RUN} topState_e;
  typedef enum logic {F_IDLE, F_BUSY}    fmState_e;
  typedef enum logic {K_IDLE, K_BUSY}    kState_e;

  topState_e            top_q, top_d;
  fmState_e             fmState_q, fmState_d;
  kState_e              kState_q, kState_d;
  logic [3:0]           fmId_q, fmId_d;
  logic [3:0]           kId_q, kId_d;
  logic [CNT_W-1:0]     fmCnt_q, fmCnt_d;
  logic [CNT_W-1:0]     kCnt_q, kCnt_d;
  logic                 kSlot_q, kSlot_d;
  logic [15:0]          fmData_q, fmData_d;
  logic [FM_ADDR_W-1:0] fmAddr_q, fmAddr_d;
  logic                 fmReady_q, fmReady_d;
  logic                 kReady_q, kReady_d;
  logic                 initDone_q, initDone_d;
  logic                 fmDone_q, fmDone_d;
  logic                 kDone_q, kDone_d;
  logic                 err_q, err_d;

  logic fmAccept, kAccept, fmMatch, kMatch, fmExpire, kExpire;

  // Status bits above the FM echo field carry nothing for this block.
  logic [20:0] sig_unused;
  assign sig_unused = sig_in[31:11];

  // IDs skip 0: the loader's echo idles at 0 and must never look like a match.
  function automatic logic [3:0] nextId(input logic [3:0] id);
    return (id == 4'd15) ? 4'd1 : id + 4'd1;
  endfunction

  assign fmAccept = fm_req_valid && fmReady_q;
  assign kAccept  = kern_req_valid && kReady_q;
  assign fmMatch  = sig_in[1] && (sig_in[10:7] == fmId_q);
  assign kMatch   = sig_in[2] && (sig_in[6:3] == kId_q);
  assign fmExpire = (fmCnt_q == TIMEOUT_LAST);
  assign kExpire  = (kCnt_q == TIMEOUT_LAST);

  // Next-state logic for the top-level init FSM and both request channels.
  always_comb begin
    top_d      = top_q;
    fmState_d  = fmState_q;
    kState_d   = kState_q;
    fmId_d     = fmId_q;
    kId_d      = kId_q;
    fmCnt_d    = fmCnt_q;
    kCnt_d     = kCnt_q;
    kSlot_d    = kSlot_q;
    fmData_d   = fmData_q;
    fmAddr_d   = fmAddr_q;
    initDone_d = initDone_q;
    err_d      = err_q;
    fmDone_d   = 1'b0;
    kDone_d    = 1'b0;

    if ((top_q == TOP_INIT) && sig_in[0]) begin
      top_d      = TOP_RUN;
      initDone_d = 1'b1;
    end

    case (fmState_q)
      F_IDLE: begin
        if (fmAccept) begin
          fmState_d = F_BUSY;
          fmId_d    = nextId(fmId_q);
          fmData_d  = fm_req_data;
          fmAddr_d  = fm_req_addr;
          fmCnt_d   = '0;
        end
      end
      F_BUSY: begin
        if (fmMatch) begin
          fmState_d = F_IDLE;
          fmDone_d  = 1'b1;
        end else if (fmExpire) begin
          fmState_d = F_IDLE;
          err_d     = 1'b1;
        end else begin
          fmCnt_d = fmCnt_q + CNT_W'(1);
        end
      end
      default: fmState_d = F_IDLE;
    endcase

    case (kState_q)
      K_IDLE: begin
        if (kAccept) begin
          kState_d = K_BUSY;
          kId_d    = nextId(kId_q);
          kSlot_d  = kern_req_slot;
          kCnt_d   = '0;
        end
      end
      K_BUSY: begin
        if (kMatch) begin
          kState_d = K_IDLE;
          kDone_d  = 1'b1;
        end else if (kExpire) begin
          kState_d = K_IDLE;
          err_d    = 1'b1;
        end else begin
          kCnt_d = kCnt_q + CNT_W'(1);
        end
      end
      default: kState_d = K_IDLE;
    endcase

    fmReady_d = (top_d == TOP_RUN) && (fmState_d == F_IDLE);
    kReady_d  = (top_d == TOP_RUN) && (kState_d == K_IDLE);
  end

  // State register; reset drops any outstanding request and rewinds the IDs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q      <= TOP_INIT;
      fmState_q  <= F_IDLE;
      kState_q   <= K_IDLE;
      fmId_q     <= '0;
      kId_q      <= '0;
      fmCnt_q    <= '0;
      kCnt_q     <= '0;
      kSlot_q    <= 1'b0;
      fmData_q   <= '0;
      fmAddr_q   <= '0;
      fmReady_q  <= 1'b0;
      kReady_q   <= 1'b0;
      initDone_q <= 1'b0;
      fmDone_q   <= 1'b0;
      kDone_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      top_q      <= top_d;
      fmState_q  <= fmState_d;
      kState_q   <= kState_d;
      fmId_q     <= fmId_d;
      kId_q      <= kId_d;
      fmCnt_q    <= fmCnt_d;
      kCnt_q     <= kCnt_d;
      kSlot_q    <= kSlot_d;
      fmData_q   <= fmData_d;
      fmAddr_q   <= fmAddr_d;
      fmReady_q  <= fmReady_d;
      kReady_q   <= kReady_d;
      initDone_q <= initDone_d;
      fmDone_q   <= fmDone_d;
      kDone_q    <= kDone_d;
      err_q      <= err_d;
    end
  end

  // Command word bits are straight flop outputs; the busy states are the request bits.
  assign sig_1 = {20'b0, fmId_q, kId_q, kSlot_q, (kState_q == K_BUSY),
                  (fmState_q == F_BUSY), (top_q == TOP_INIT)};
  assign sig_2          = {16'b0, fmData_q};
  assign sig_3          = 32'(fmAddr_q);
  assign fm_req_ready   = fmReady_q;
  assign kern_req_ready = kReady_q;
  assign init_done      = initDone_q;
  assign fm_done        = fmDone_q;
  assign kern_done      = kDone_q;
  assign err_timeout    = err_q;

endmodule
